// File: rtl/cell_rd_pkg.sv
// Shared types and constants for the cell position reader.
package cell_rd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_CNT   = 3'd1,
    WAIT_CNT = 3'd2,
    STREAM   = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int RAM_RD_LATENCY = 2;
  localparam int COUNT_ADDR     = 0;

endpackage

// File: rtl/cell_rd_fifo.sv
// Show-ahead synchronous FIFO buffering particle words ahead of the consumer.
module cell_rd_fifo #(
  parameter int WIDTH = 105,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cell_pos_reader.sv
// Reads the particle count at address 0, then streams particles 1..count over valid/ready.
// Optional CELL_RD_CNT_CHECK_EN: clamps an oversized count and flags it on cnt_err.
module cell_pos_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_cnt
`ifdef CELL_RD_CNT_CHECK_EN
  ,
  output logic                  cnt_err
`endif
);

  import cell_rd_pkg::*;

  localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int KW = CW + 2;

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARTICLE_NUM > (1 << ADDR_WIDTH)) begin : g_cfg_check
    $error("cell_pos_reader: illegal parameter set");
  end

  state_t                state;
  logic [1:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic [ADDR_WIDTH-1:0] cnt_use;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  vld_p0, vld_p1, vld_p2;
  logic [ADDR_WIDTH-1:0] pid_p1, pid_p2;
  logic [1:0]            in_flight;
  logic [KW-1:0]         occ_next;
  logic                  credit_ok;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [FW-1:0]         fifo_in;
  logic [FW-1:0]         fifo_out;

  assign cnt_raw = mem_q[ADDR_WIDTH-1:0];

`ifdef CELL_RD_CNT_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  function automatic logic [ADDR_WIDTH-1:0] sat_count(input logic [ADDR_WIDTH-1:0] c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  logic cnt_over;
  assign cnt_use  = sat_count(cnt_raw);
  assign cnt_over = (cnt_raw > CNT_MAX);
`else
  assign cnt_use = cnt_raw;
`endif

  assign next_addr = mem_address + ADDR_WIDTH'(1);
  assign pop       = out_valid && out_ready;

  // Credit: reads still in the RAM pipe plus the FIFO occupancy after this edge must leave a slot.
  assign in_flight = 2'(vld_p0) + 2'(vld_p1);
  assign occ_next  = KW'(fifo_count) + KW'(vld_p2) - KW'(pop);
  assign credit_ok = !fifo_full && ((occ_next + KW'(in_flight)) < KW'(FIFO_DEPTH));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      mem_address  <= '0;
      mem_rden     <= 1'b0;
      vld_p0       <= 1'b0;
      particle_cnt <= '0;
`ifdef CELL_RD_CNT_CHECK_EN
      cnt_err      <= 1'b0;
`endif
    end else begin
      mem_rden <= 1'b0;
      vld_p0   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RD_CNT;
            mem_address <= ADDR_WIDTH'(COUNT_ADDR);
            mem_rden    <= 1'b1;
`ifdef CELL_RD_CNT_CHECK_EN
            cnt_err     <= 1'b0;
`endif
          end
        end
        RD_CNT: begin
          state    <= WAIT_CNT;
          wait_cnt <= '0;
        end
        WAIT_CNT: begin
          if (wait_cnt == 2'(RAM_RD_LATENCY - 1)) begin
            particle_cnt <= cnt_use;
`ifdef CELL_RD_CNT_CHECK_EN
            cnt_err      <= cnt_over;
`endif
            if (cnt_use == '0) begin
              state <= DONE;
            end else begin
              mem_address <= ADDR_WIDTH'(1);
              mem_rden    <= 1'b1;
              vld_p0      <= 1'b1;
              state       <= (cnt_use == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        STREAM: begin
          if (credit_ok) begin
            mem_address <= next_addr;
            mem_rden    <= 1'b1;
            vld_p0      <= 1'b1;
            if (next_addr == particle_cnt) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM return pipeline: p0 = read presented, p2 = data on mem_q
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clock) begin
    pid_p1 <= mem_address;
    pid_p2 <= pid_p1;
  end

  assign fifo_in = {(pid_p2 == particle_cnt), pid_p2, mem_q};

  cell_rd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (vld_p2),
    .push_data (fifo_in),
    .pop       (pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = fifo_out[FW-1];
  assign out_pid   = fifo_out[FW-2 -: ADDR_WIDTH];
  assign out_pos   = fifo_out[DATA_WIDTH-1:0];

  assign mem_wren = 1'b0;
  assign busy     = (state == RD_CNT) || (state == WAIT_CNT) ||
                    (state == STREAM) || (state == DRAIN);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader with a 2-cycle-latency RAM model.
module tb_cell_pos_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int FD = 4;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] mem_address;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_q = '0;
  logic          out_valid;
  logic [DW-1:0] out_pos;
  logic [AW-1:0] out_pid;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [AW-1:0] particle_cnt;
`ifdef CELL_RD_CNT_CHECK_EN
  logic          cnt_err;
`endif

  logic [DW-1:0] ram [256];
  logic [DW-1:0] rd_d1 = '0;

  int passes = 0;
  int total  = 0;

  int issued, hs, max_out, order_err, stall_err, done_cnt, last_seen, valid_seen, exp_pid;
  logic [AW-1:0] max_addr;
  bit            saw_addr1;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_pos;
  logic [AW-1:0] prev_pid;
  logic          prev_last;

  cell_pos_reader #(
    .DATA_WIDTH   (DW),
    .PARTICLE_NUM (PN),
    .ADDR_WIDTH   (AW),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .start        (start),
    .mem_address  (mem_address),
    .mem_rden     (mem_rden),
    .mem_wren     (mem_wren),
    .mem_q        (mem_q),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pos      (out_pos),
    .out_pid      (out_pid),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .particle_cnt (particle_cnt)
`ifdef CELL_RD_CNT_CHECK_EN
    ,
    .cnt_err      (cnt_err)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    rd_d1 <= mem_rden ? ram[mem_address] : '0;
    mem_q <= rd_d1;
  end

  function automatic logic [DW-1:0] pos_of(input int k);
    return {32'hC000_0000 + 32'(k * 7), 32'hB000_0000 + 32'(k * 5), 32'hA000_0000 + 32'(k)};
  endfunction

  always @(negedge clock) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_rden && mem_address != '0) begin
        issued++;
        if (mem_address > max_addr) max_addr = mem_address;
        if (mem_address == AW'(1)) saw_addr1 = 1'b1;
      end
      if (out_valid) valid_seen++;
      if (prev_stall && (!out_valid || out_pos !== prev_pos || out_pid !== prev_pid ||
                         out_last !== prev_last))
        stall_err++;
      if (out_valid && out_ready) begin
        if (out_pid !== AW'(exp_pid) || out_pos !== pos_of(exp_pid)) order_err++;
        if (out_last) begin
          last_seen++;
          if (out_pid !== particle_cnt) order_err++;
        end
        exp_pid++;
        hs++;
      end
      if (done) done_cnt++;
      if (issued - hs > max_out) max_out = issued - hs;
      prev_stall = out_valid && !out_ready;
      prev_pos   = out_pos;
      prev_pid   = out_pid;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr_mon();
    issued = 0; hs = 0; max_out = 0; order_err = 0; stall_err = 0;
    done_cnt = 0; last_seen = 0; valid_seen = 0; exp_pid = 1;
    max_addr = '0; saw_addr1 = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {out_valid, busy, done, mem_rden, mem_wren, out_last}, 6'b0);
    check({tag, "_addr"}, {mem_address, out_pid, particle_cnt}, '0);
    check({tag, "_pos"}, out_pos, '0);
  endtask

  initial begin
    int n;
    clr_mon();
    for (int k = 1; k < 256; k++) ram[k] = pos_of(k);
    ram[0] = '0;

    tick(); tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick(); tick();

    // T1: count 3, consumer always ready, exact cycle timing
    out_ready = 1'b1;
    clr_mon();
    ram[0] = {88'hA5A5, 8'd3};
    start = 1'b1; tick(); start = 1'b0;
    check("t1_c1_rd", {mem_rden, busy, mem_address}, {2'b11, 8'd0});
    tick();
    check("t1_c2_rden", mem_rden, 1'b0);
    tick(); tick();
    check("t1_c4_addr1", {mem_rden, mem_address}, {1'b1, 8'd1});
    check("t1_cnt", particle_cnt, 8'd3);
    tick(); tick();
    check("t1_c6_addr3", {mem_rden, mem_address, out_valid}, {1'b1, 8'd3, 1'b0});
    for (int c = 7; c <= 9; c++) begin
      tick();
      check("t1_out", {out_valid, out_last, out_pid}, {1'b1, (c == 9), AW'(c - 6)});
      check("t1_pos", out_pos, pos_of(c - 6));
    end
    tick();
    check("t1_c10_done", {done, busy, out_valid}, 3'b100);
    tick();
    check("t1_done_pulse", {done, hs, order_err}, {1'b0, 32'd3, 32'd0});

    // T2: empty cell
    clr_mon();
    ram[0] = {88'hFFFF_FFFF, 8'd0};
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("t2_c3_busy", {busy, done}, 2'b10);
    tick();
    check("t2_c4_done", {busy, done}, 2'b01);
    for (int i = 0; i < 6; i++) tick();
    check("t2_once", {done_cnt, valid_seen}, {32'd1, 32'd0});
    check("t2_no_addr1", {saw_addr1, busy, particle_cnt}, {1'b0, 1'b0, 8'd0});

    // T3: count 10, random backpressure
    clr_mon();
    ram[0] = {88'h0, 8'd10};
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("t3_done_seen", done, 1'b1);
    out_ready = 1'b1;
    tick();
    check("t3_hs", {hs, order_err, last_seen}, {32'd10, 32'd0, 32'd1});
    check("t3_stall_stable", stall_err, 0);
    check("t3_credit", (max_out <= FD), 1'b1);
    check("t3_cnt", {particle_cnt, done_cnt}, {8'd10, 32'd1});

    // T4: reset in mid-stream, then a clean restart
    clr_mon();
    ram[0] = {88'h0, 8'd8};
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (hs < 4 && n < 60) begin
      tick();
      n++;
    end
    check("t4_hs4", hs, 4);
    rst_n = 1'b0;
    tick();
    check_zero("t4_rst");
    rst_n = 1'b1;
    tick(); tick();
    clr_mon();
    start = 1'b1; tick(); start = 1'b0;
    wait_done("t4_done_seen", 100);
    tick();
    check("t4_restream", {hs, order_err, last_seen}, {32'd8, 32'd0, 32'd1});
    check("t4_max_addr", max_addr, 8'd8);

    // T5: start while busy and during the done cycle
    clr_mon();
    ram[0] = {88'h0, 8'd2};
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t5_c9_done", {done, busy}, 2'b10);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_c10_idle", {done, busy}, 2'b00);
    tick();
    check("t5_c11_norestart", {mem_rden, busy}, 2'b00);
    for (int i = 0; i < 8; i++) tick();
    check("t5_once", {done_cnt, hs}, {32'd1, 32'd2});

`ifdef CELL_RD_CNT_CHECK_EN
    // T6: oversized count is clamped
    clr_mon();
    ram[0] = {88'h0, 8'd250};
    start = 1'b1; tick(); start = 1'b0;
    wait_done("t6_done_seen", 800);
    tick();
    check("t6_err", {cnt_err, particle_cnt}, {1'b1, 8'd219});
    check("t6_stream", {hs, order_err, max_addr}, {32'd219, 32'd0, 8'd219});
    clr_mon();
    ram[0] = {88'h0, 8'd3};
    start = 1'b1; tick(); start = 1'b0;
    check("t6_err_clear", cnt_err, 1'b0);
    wait_done("t6_done2", 100);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
